// File: rtl/uart_tx_if.sv
// uart_tx byte handshake: fabric (master) offers a byte,
// transmitter (slave) accepts it when ready.
interface uart_tx_if;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;

  modport master (
    output i_valid,
    output i_data,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_ready
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter, LSB first, fixed CLK_PER_BIT divide.
// Optional parity bit: define UART_TX_PARITY_EN (adds PARITY_ODD).
module uart_tx #(
  parameter int CLK_PER_BIT = 833,
  parameter int STOP_BITS   = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter int PARITY_ODD  = 0
`endif
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  s_if,
  output logic      o_tx,
  output logic      o_busy,
  output logic      o_done
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    SLAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  logic w_last;
  logic w_hs;

  assign w_last = (r_cnt == LAST);
  assign w_hs   = s_if.i_valid && r_ready;

  // r_tx is decoded from the current state, so the line lags
  // the state by one clock and only moves on bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE)
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_hs) begin
            r_state <= S_START;
            r_shift <= s_if.i_data;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= (^s_if.i_data) ^ (PARITY_ODD != 0);
`endif
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_last)
            r_state <= S_DATA;
        end
        S_DATA: begin
          r_tx <= r_shift[r_idx];
          if (w_last) begin
            if (r_idx == 3'd7) begin
              r_idx   <= '0;
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          r_tx <= r_par;
          if (w_last)
            r_state <= S_STOP;
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_last) begin
            if (r_idx == SLAST) begin
              r_state <= S_IDLE;
              r_idx   <= '0;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_if.o_ready = r_ready;
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
